// File: rtl/bus_arbiter_rr_pkg.sv
// Shared constants and types for the round-robin bus arbiter: master count limit,
// default tenure, grant pin polarity and the per-cycle arbitration decision.
package bus_arbiter_rr_pkg;

  localparam int BUS_ARB_MAX_MASTERS = 16;
  localparam int DEFAULT_MAX_HOLD    = 16;

  // Grant pins are active-low on the bus.
  localparam logic GRANT_ON  = 1'b0;
  localparam logic GRANT_OFF = 1'b1;

  typedef enum logic [1:0] {
    DEC_PARK,     // nobody requests: stay on the last owner
    DEC_KEEP,     // owner requests and keeps the bus
    DEC_PREEMPT,  // owner's tenure expired while others wait
    DEC_HANDOFF   // owner released, pass to the next requester
  } arb_dec_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Rotate-priority picker: finds the first set request bit strictly after base,
// scanning base+1 .. base with wrap-around.
module bus_rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  localparam int OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWN_W-1:0]       base,
  output logic                   found,
  output logic [OWN_W-1:0]       idx
);

  int pos;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      pos = int'(base) + i;
      if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = OWN_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with parking, bounded tenure and owner bus lock.
// Holds the owner register, tenure counter and preempt flag; grants decode from owner.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int MAX_HOLD    = DEFAULT_MAX_HOLD,
  parameter  int HOLD_W      = 8,
  localparam int OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  input  logic [NUM_MASTERS-1:0] lock_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWN_W-1:0]       owner,
  output logic                   preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]      hold_cnt, next_hold;
  logic [OWN_W-1:0]       next_owner, pick_idx;
  logic                   next_preempt;
  logic [NUM_MASTERS-1:0] req, others;
  logic                   owner_req, locked, expired, pick_found;
  arb_dec_e               dec;

  always_comb begin
    req           = ~req_;
    others        = req;
    others[owner] = 1'b0;
  end

  assign owner_req = req[owner];
  assign locked    = owner_req && (lock_[owner] == 1'b0);
  // pick_found doubles as "some other master is requesting".
  assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && pick_found;

  bus_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req   (others),
    .base  (owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    if (owner_req)       dec = (expired && !locked) ? DEC_PREEMPT : DEC_KEEP;
    else if (pick_found) dec = DEC_HANDOFF;
    else                 dec = DEC_PARK;
  end

  always_comb begin
    next_owner   = owner;
    next_hold    = '0;
    next_preempt = 1'b0;
    case (dec)
      DEC_KEEP: begin
        // Saturation at HOLD_LAST only persists while locked; unlocked it preempts instead.
        if (pick_found)
          next_hold = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_W'(1);
      end
      DEC_PREEMPT: begin
        next_owner   = pick_idx;
        next_preempt = 1'b1;
      end
      DEC_HANDOFF: next_owner = pick_idx;
      default:     next_owner = owner;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      owner    <= next_owner;
      hold_cnt <= next_hold;
      preempt  <= next_preempt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      grnt_[i] = (owner == OWN_W'(i)) ? GRANT_ON : GRANT_OFF;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (4 masters, MAX_HOLD=4): reset, rotation, parking,
// tenure preemption, lock, simultaneous drop/expiry and reset mid-operation.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_, lock_, grnt_;
  logic [1:0] owner;
  logic       preempt;
  int         checks = 0;
  int         errors = 0;

  bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_    (req_),
    .lock_   (lock_),
    .grnt_   (grnt_),
    .owner   (owner),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_  = 4'($urandom);
      lock_ = 4'($urandom);
      tick();
    end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    checks++; if (grnt_ !== 4'b1110) begin errors++; $display("FAIL reset_grnt got %b want 1110", grnt_); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got %b want 0", preempt); end
    reset = 1'b0;
    req_  = 4'b1111;
    lock_ = 4'b1111;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] vec [6] = '{4'b1101, 4'b0110, 4'b1110, 4'b0001, 4'b0011, 4'b0111};
    logic [1:0] exp [6] = '{2'd1,    2'd3,    2'd0,    2'd1,    2'd2,    2'd3};
    for (int i = 0; i < 6; i++) begin
      req_ = vec[i];
      tick();
      checks++; if (owner !== exp[i]) begin errors++; $display("FAIL rotation_owner[%0d] got %0d want %0d", i, owner, exp[i]); end
      checks++; if (grnt_ !== ~(4'b0001 << exp[i])) begin errors++; $display("FAIL rotation_grnt[%0d] got %b want %b", i, grnt_, ~(4'b0001 << exp[i])); end
      checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL rotation_preempt[%0d] got %b want 0", i, preempt); end
    end
    req_ = 4'b1110;
    tick();
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rotation_wrap got %0d want 0", owner); end
  endtask

  task automatic test_parking();
    req_ = 4'b1011;
    tick();
    req_ = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (owner !== 2'd2) begin errors++; $display("FAIL park_owner[%0d] got %0d want 2", i, owner); end
      checks++; if (grnt_ !== 4'b1011) begin errors++; $display("FAIL park_grnt[%0d] got %b want 1011", i, grnt_); end
    end
  endtask

  task automatic test_tenure();
    logic [1:0] exp_own [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic       exp_pre [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    req_ = 4'b1110;
    tick();
    req_ = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (owner !== exp_own[i]) begin errors++; $display("FAIL tenure_owner[%0d] got %0d want %0d", i, owner, exp_own[i]); end
      checks++; if (preempt !== exp_pre[i]) begin errors++; $display("FAIL tenure_preempt[%0d] got %b want %b", i, preempt, exp_pre[i]); end
    end
  endtask

  task automatic test_lock();
    req_ = 4'b1110;
    tick();
    req_  = 4'b1010;
    lock_ = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (owner !== 2'd0 || preempt !== 1'b0) begin errors++; $display("FAIL lock_hold[%0d] got owner %0d preempt %b want 0 0", i, owner, preempt); end
    end
    checks++; if (dut.hold_cnt !== 8'd3) begin errors++; $display("FAIL lock_saturate got %0d want 3", dut.hold_cnt); end
    lock_ = 4'b1111;
    tick();
    checks++; if (owner !== 2'd2 || preempt !== 1'b1) begin errors++; $display("FAIL lock_release got owner %0d preempt %b want 2 1", owner, preempt); end
    tick();
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL lock_pulse got %b want 0", preempt); end
  endtask

  task automatic test_simultaneous();
    req_ = 4'b1110;
    tick();
    req_ = 4'b1010;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (owner !== 2'd0 || dut.hold_cnt !== 8'd3) begin errors++; $display("FAIL simul_setup got owner %0d hold %0d want 0 3", owner, dut.hold_cnt); end
    req_ = 4'b1011;
    tick();
    checks++; if (owner !== 2'd2 || preempt !== 1'b0) begin errors++; $display("FAIL simul_drop got owner %0d preempt %b want 2 0", owner, preempt); end
  endtask

  task automatic test_nonowner_lock();
    req_  = 4'b1010;
    lock_ = 4'b1110;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (owner !== 2'd0 || preempt !== 1'b1) begin errors++; $display("FAIL nonowner_lock got owner %0d preempt %b want 0 1", owner, preempt); end
    req_ = 4'b1011;
    tick();
    checks++; if (owner !== 2'd2 || preempt !== 1'b0) begin errors++; $display("FAIL lock_drop got owner %0d preempt %b want 2 0", owner, preempt); end
  endtask

  task automatic test_reset_mid();
    req_  = 4'b0111;
    lock_ = 4'b0111;
    tick();
    req_ = 4'b0110;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (owner !== 2'd3 || dut.hold_cnt !== 8'd3) begin errors++; $display("FAIL midrst_setup got owner %0d hold %0d want 3 3", owner, dut.hold_cnt); end
    reset = 1'b1;
    tick();
    checks++; if (owner !== 2'd0 || grnt_ !== 4'b1110) begin errors++; $display("FAIL midrst_owner got owner %0d grnt %b want 0 1110", owner, grnt_); end
    checks++; if (dut.hold_cnt !== 8'd0 || preempt !== 1'b0) begin errors++; $display("FAIL midrst_state got hold %0d preempt %b want 0 0", dut.hold_cnt, preempt); end
    reset = 1'b0;
    req_  = 4'b1111;
    lock_ = 4'b1111;
    tick();
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL midrst_after got %0d want 0", owner); end
  endtask

  initial begin
    reset = 1'b1;
    req_  = 4'b1111;
    lock_ = 4'b1111;
    test_reset();
    test_rotation();
    test_parking();
    test_tenure();
    test_lock();
    test_simultaneous();
    test_nonowner_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
